// File: rtl/wb_byte_cmd_master_if.sv
// rtl/wb_byte_cmd_master_if.sv - command/response stream and Wishbone bus bundle for wb_byte_cmd_master
//
// Purpose: groups the byte-stream command channel, the byte-stream response
// channel, the Wishbone initiator signals and the status flags into one bundle.
// Ports (signal view):
//   cmd_data_i[7:0], cmd_valid_i, cmd_ready_o     command byte stream into the master
//   rsp_data_o[7:0], rsp_valid_o, rsp_ready_i     response byte stream out of the master
//   wb_adr_o[15:0], wb_dat_o[7:0], wb_dat_i[7:0]  Wishbone address / write data / read data
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i         Wishbone control
//   busy_o, timeout_o                             status flags
// Modports: master (the design), slave (host, bus and status observer side).

interface wb_byte_cmd_master_if;
    logic [7:0]  cmd_data_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic        wb_ack_i;
    logic        busy_o;
    logic        timeout_o;

    modport master (
        input  cmd_data_i, cmd_valid_i, rsp_ready_i, wb_dat_i, wb_ack_i,
        output cmd_ready_o, rsp_data_o, rsp_valid_o, wb_adr_o, wb_dat_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, busy_o, timeout_o
    );

    modport slave (
        output cmd_data_i, cmd_valid_i, rsp_ready_i, wb_dat_i, wb_ack_i,
        input  cmd_ready_o, rsp_data_o, rsp_valid_o, wb_adr_o, wb_dat_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, busy_o, timeout_o
    );
endinterface

// File: rtl/wb_byte_cmd_master.sv
// rtl/wb_byte_cmd_master.sv - byte-stream command to single-cycle Wishbone master with bus watchdog
//
// Purpose: accepts 0x57 hi lo data (write) and 0x52 hi lo (read) commands,
// runs one Wishbone cycle, returns a status byte (06 ack, 15 timeout,
// 3F unknown opcode) followed by a read data byte for reads.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   wb_byte_cmd_master_if.master (command/response streams, Wishbone, busy/timeout)
// Parameter: TIMEOUT_CYCLES - BUS cycles without ack before the cycle is aborted (1..65535).

module wb_byte_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_byte_cmd_master_if.master    bus
);
    localparam logic [7:0]  OP_WRITE = 8'h57;
    localparam logic [7:0]  OP_READ  = 8'h52;
    localparam logic [7:0]  ST_ACK   = 8'h06;
    localparam logic [7:0]  ST_TMO   = 8'h15;
    localparam logic [7:0]  ST_BADOP = 8'h3F;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, DATA, BUS, RSP_STATUS, RSP_DATA
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;         // command direction latched from the opcode
    logic        rd_q, rd_d;         // a read opcode was received: send a data byte after status
    logic [15:0] adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic        cyc_q, cyc_d;       // drives both cyc and stb
    logic        wb_we_q, wb_we_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        timeout_q, timeout_d;
    logic        cmd_ready;
    logic        cmd_fire;
    logic        go_bus;

    // Ready is held low while rst is asserted even though state is already IDLE.
    assign cmd_ready = !rst && (state_q == IDLE || state_q == ADDR_HI ||
                                state_q == ADDR_LO || state_q == DATA);
    assign cmd_fire  = bus.cmd_valid_i && cmd_ready;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        rd_d        = rd_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cyc_d       = cyc_q;
        wb_we_d     = wb_we_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        timeout_d   = 1'b0;
        go_bus      = 1'b0;

        case (state_q)
            IDLE: if (cmd_fire) begin
                if (bus.cmd_data_i == OP_WRITE) begin
                    we_d    = 1'b1;
                    rd_d    = 1'b0;
                    state_d = ADDR_HI;
                end else if (bus.cmd_data_i == OP_READ) begin
                    we_d    = 1'b0;
                    rd_d    = 1'b1;
                    state_d = ADDR_HI;
                end else begin
                    rd_d        = 1'b0;
                    rsp_data_d  = ST_BADOP;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP_STATUS;
                end
            end
            ADDR_HI: if (cmd_fire) begin
                adr_d[15:8] = bus.cmd_data_i;
                state_d     = ADDR_LO;
            end
            ADDR_LO: if (cmd_fire) begin
                adr_d[7:0] = bus.cmd_data_i;
                if (we_q) state_d = DATA;
                else      go_bus  = 1'b1;
            end
            DATA: if (cmd_fire) begin
                dat_d  = bus.cmd_data_i;
                go_bus = 1'b1;
            end
            BUS: begin
                cnt_d = cnt_q + 16'd1;
                // Ack has priority over the watchdog in the same cycle.
                if (bus.wb_ack_i) begin
                    cyc_d       = 1'b0;
                    wb_we_d     = 1'b0;
                    if (!we_q) rd_data_d = bus.wb_dat_i;
                    rsp_data_d  = ST_ACK;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP_STATUS;
                end else if (cnt_q == TO_LAST) begin
                    cyc_d       = 1'b0;
                    wb_we_d     = 1'b0;
                    rd_data_d   = 8'h00;
                    rsp_data_d  = ST_TMO;
                    rsp_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = RSP_STATUS;
                end
            end
            RSP_STATUS: if (rsp_valid_q && bus.rsp_ready_i) begin
                if (rd_q) begin
                    rsp_data_d = rd_data_q;
                    state_d    = RSP_DATA;
                end else begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            RSP_DATA: if (rsp_valid_q && bus.rsp_ready_i) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus entry: strobe asserted from the first BUS cycle, watchdog cleared.
        if (go_bus) begin
            cyc_d   = 1'b1;
            wb_we_d = we_q;
            cnt_d   = 16'd0;
            state_d = BUS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            adr_q       <= 16'd0;
            dat_q       <= 8'd0;
            cyc_q       <= 1'b0;
            wb_we_q     <= 1'b0;
            cnt_q       <= 16'd0;
            rd_data_q   <= 8'd0;
            rsp_data_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            wb_we_q     <= wb_we_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_we_o     = wb_we_q;
    assign bus.timeout_o   = timeout_q;
endmodule

// File: doc/wb_byte_cmd_master.md
Name: wb_byte_cmd_master

Overview:
- Wishbone initiator that drives the 16-bit address / 8-bit data bus feeding the 4-slave address decoder.
- Converts a byte-stream command channel (from a UART/SPI receiver) into single Wishbone read/write cycles.
- Returns status and read data on a byte-stream response channel.
- Includes a bus-timeout watchdog so that accesses to a non-acking slave do not hang the host link.

Parameters:
TIMEOUT_CYCLES, 255, number of BUS-state cycles without wb_ack_i before the cycle is aborted (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_data_i  in  8  command stream byte
cmd_valid_i  in  1  command byte valid
cmd_ready_o  out  1  block accepts command byte
rsp_data_o  out  8  response stream byte
rsp_valid_o  out  1  response byte valid
rsp_ready_i  in  1  consumer accepts response byte
wb_adr_o  out  16  Wishbone address
wb_dat_o  out  8  Wishbone write data
wb_dat_i  in  8  Wishbone read data (from decoder mux)
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_ack_i  in  1  Wishbone acknowledge (OR of slave acks)
busy_o  out  1  high in any state other than IDLE
timeout_o  out  1  one-cycle pulse when a cycle is aborted by the watchdog

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: state=IDLE; wb_adr_o=0, wb_dat_o=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0; rsp_data_o=0, rsp_valid_o=0; busy_o=0, timeout_o=0; cmd_ready_o=0 while rst is high.
- All outputs are registered except cmd_ready_o and busy_o, which are decoded from the state.
- Stream handshake: a byte transfers on a clk edge where valid and ready are both high.
  - rsp_valid_o, once set, holds with rsp_data_o stable until rsp_ready_i is high.
  - cmd_ready_o=1 only in IDLE, ADDR_HI, ADDR_LO and DATA.
- Command format:
  - Write: 0x57, addr_hi, addr_lo, data.
  - Read: 0x52, addr_hi, addr_lo.
- States:
  - IDLE: on accepting 0x57, set we=1 and go to ADDR_HI. On 0x52, set we=0 and go to ADDR_HI. On any other byte, load rsp 0x3F and go to RSP_STATUS (no bus cycle).
  - ADDR_HI: accept byte into wb_adr_o[15:8]; go to ADDR_LO.
  - ADDR_LO: accept byte into wb_adr_o[7:0]. If we=1, go to DATA. If we=0, go to BUS.
  - DATA: accept byte into wb_dat_o; go to BUS.
  - BUS: wb_cyc_o=wb_stb_o=1 and wb_we_o=we from the first BUS cycle; adr/dat held constant. Timeout counter clears on BUS entry and increments each BUS cycle.
    - If wb_ack_i=1: drop cyc/stb/we next edge. Capture wb_dat_i on the ack edge when reading. Status=0x06. Go to RSP_STATUS.
    - Else if the counter equals TIMEOUT_CYCLES-1: drop cyc/stb/we next edge. Status=0x15, read data=0x00, pulse timeout_o. Go to RSP_STATUS.
    - If ack and timeout occur in the same cycle, ack wins and there is no timeout pulse.
  - RSP_STATUS: present status. When it is accepted, go to RSP_DATA if it was a read with status 0x06 or 0x15; otherwise go to IDLE.
  - RSP_DATA: present the read data byte; on acceptance go to IDLE.
- wb_ack_i is ignored outside BUS, so late acks after an abort have no effect.
- Latency: last command byte accepted at edge N → cyc/stb high after edge N. With a zero-wait slave acking in that cycle: cyc low and rsp_valid_o high after edge N+1.
- One Wishbone cycle is outstanding at most; no pipelining and no command overlap. cmd_ready_o=0 from BUS until the response completes.
- Reset mid-operation: cyc/stb drop asynchronously, the partial command is discarded, and any pending response is lost.
- Address and data are fully 16/8-bit; no wrap or auto-increment.

Test Plan:
- Write to RGB LED: bytes 57 80 05 A5, slave acks the first cycle → wb_adr_o=0x8005, wb_dat_o=0xA5, we=1, cyc high exactly 1 cycle, response 06.
- Read from HQVGA with 3 wait states: 52 12 34, slave drives 0x3C with ack on the 4th BUS cycle → cyc high 4 cycles, we=0, response 06 3C.
- Timeout with TIMEOUT_CYCLES=8: 52 90 00 and no ack → cyc high exactly 8 cycles, timeout_o one pulse, response 15 00. An ack injected 2 cycles later is ignored.
- Back-pressure: hold rsp_ready_i=0 for 10 cycles after a read → rsp_valid_o and rsp_data_o stay stable, cmd_ready_o stays 0, and the next command is accepted only after 2 response transfers.
- Unknown opcode 0xAA → no cyc assertion, response 3F. A following 57 81 00 01 executes normally and returns 06.
- Assert rst during BUS of a write → cyc/stb/we go 0 immediately, state returns to IDLE, no response byte, cmd_ready_o=1 after rst is released.
